// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM generator slaved to an external free-running up counter.
// Duty is double-buffered (pending -> active) and only swapped at counter wrap.
// Optional feature: define PWM_WRAP_CNT_EN to add the 8-bit wrap_cnt output.
module count_pwm_gen #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned RESET_DUTY = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             wrap_tick,
  output logic             sync_err
`ifdef PWM_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  localparam int unsigned     DW       = WIDTH + 1;
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [DW-1:0]    DUTY_MAX = DW'(2 ** WIDTH);
  localparam logic [DW-1:0]    DUTY_RST = DW'(RESET_DUTY);

  typedef enum logic {
    WAIT_WRAP = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t           state;
  logic [DW-1:0]    active_duty;
  logic [DW-1:0]    pending_duty;
  logic [WIDTH-1:0] prev_count;

  logic             is_max;
  logic             accept;
  logic [DW-1:0]    duty_clamped;
  logic [WIDTH-1:0] count_step;

  assign is_max       = (count_in == CNT_MAX);
  assign accept       = duty_valid && duty_ready;
  assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
  assign count_step   = prev_count + WIDTH'(1);

  // Synchronisation FSM: wait for the first wrap before producing PWM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_WRAP;
    end else begin
      case (state)
        WAIT_WRAP: if (is_max) state <= RUN;
        RUN:       state <= RUN;
        default:   state <= WAIT_WRAP;
      endcase
    end
  end

  // Duty double buffer: accept into pending, promote to active at wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_ready   <= 1'b1;
      pending_duty <= '0;
      active_duty  <= DUTY_RST;
    end else if (accept) begin
      pending_duty <= duty_clamped;
      duty_ready   <= 1'b0;
    end else if (is_max && !duty_ready) begin
      active_duty <= pending_duty;
      duty_ready  <= 1'b1;
    end
  end

  // PWM compare and wrap pulse, one clock behind count_in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out   <= 1'b0;
      wrap_tick <= 1'b0;
    end else begin
      pwm_out   <= (state == RUN) && ({1'b0, count_in} < active_duty);
      wrap_tick <= is_max;
    end
  end

  // Sticky discontinuity detector, armed only once running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_count <= '0;
      sync_err   <= 1'b0;
    end else begin
      prev_count <= count_in;
      if ((state == RUN) && (count_in != count_step)) sync_err <= 1'b1;
    end
  end

`ifdef PWM_WRAP_CNT_EN
  // Count wraps modulo 256, in step with wrap_tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt <= 8'd0;
    end else if (is_max) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Scoreboard bench for count_pwm_gen: driver predicts each cycle's outputs from a
// period-level model and queues them; a monitor pops and compares after each edge.
module tb_count_pwm_gen;

  localparam int PERIOD = 16;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b1;
  logic [3:0] count_in   = 4'd0;
  logic [4:0] duty_in    = 5'd0;
  logic       duty_valid = 1'b0;
  logic       duty_ready;
  logic       pwm_out;
  logic       wrap_tick;
  logic       sync_err;
`ifdef PWM_WRAP_CNT_EN
  logic [7:0] wrap_cnt;
`endif

  count_pwm_gen #(.WIDTH(4), .RESET_DUTY(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_in   (count_in),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_tick  (wrap_tick),
    .sync_err   (sync_err)
`ifdef PWM_WRAP_CNT_EN
    ,
    .wrap_cnt   (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pwm;
    bit wrap;
    bit err;
    bit ready;
    int wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int   m_active;
  int   m_prev;
  int   m_wcnt;
  bit   m_run;
  bit   m_err;
  int   m_pend[$];
  int   tb_cnt = 3;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_prev   = 0;
    m_wcnt   = 0;
    m_run    = 0;
    m_err    = 0;
    m_pend.delete();
  endtask

  // drive one cycle at the falling edge and queue the outputs expected after the next rise
  task automatic step(input bit valid, input int din, input int cnt);
    exp_t e;
    bit   acc;
    bit   wrap;
    @(negedge clk);
    reset_n    = 1'b1;
    count_in   = 4'(cnt);
    duty_valid = valid;
    duty_in    = 5'(din);
    acc  = valid && (m_pend.size() == 0);
    wrap = (cnt == PERIOD - 1);
    e.pwm  = m_run && (cnt < m_active);
    e.wrap = wrap;
    if (m_run && (cnt != (m_prev + 1) % PERIOD)) m_err = 1'b1;
    e.err = m_err;
    if (acc) m_pend.push_back((din > PERIOD) ? PERIOD : din);
    else if (wrap && m_pend.size() != 0) m_active = m_pend.pop_front();
    if (wrap) begin
      m_run  = 1'b1;
      m_wcnt = (m_wcnt + 1) % 256;
    end
    m_prev  = cnt;
    e.ready = (m_pend.size() == 0);
    e.wcnt  = m_wcnt;
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit valid, input int din);
    step(valid, din, tb_cnt);
    tb_cnt = (tb_cnt + 1) % PERIOD;
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, int'($urandom_range(31)));
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < PERIOD && tb_cnt != c; i++) tick(1'b0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pwm"},   pwm_out,    0);
    chk({tag, "_wrap"},  wrap_tick,  0);
    chk({tag, "_err"},   sync_err,   0);
    chk({tag, "_ready"}, duty_ready, 1);
`ifdef PWM_WRAP_CNT_EN
    chk({tag, "_wcnt"},  wrap_cnt,   0);
`endif
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // monitor: compare every clocked output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pwm_out",    pwm_out,    e.pwm);
        chk("wrap_tick",  wrap_tick,  e.wrap);
        chk("sync_err",   sync_err,   e.err);
        chk("duty_ready", duty_ready, e.ready);
`ifdef PWM_WRAP_CNT_EN
        chk("wrap_cnt",   wrap_cnt,   e.wcnt);
`endif
      end
    end
  end

  // stimulus
  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("init");

    // no duty load: pwm stays low, wraps every period
    run(3 * PERIOD);

    // duty 5 loaded mid-period
    run_to(7);
    tick(1'b1, 5);
    run(2 * PERIOD);

    // 0, then 16, then 20 (clamped)
    run_to(2);
    tick(1'b1, 0);
    run(2 * PERIOD);
    run_to(2);
    tick(1'b1, 16);
    run(2 * PERIOD);
    run_to(2);
    tick(1'b1, 20);
    run(2 * PERIOD);

    // request in the wrap cycle is deferred by one period
    run_to(15);
    tick(1'b1, 3);
    run(3 * PERIOD);

    // randomized requests with dropping valid
    for (int i = 0; i < 40 * PERIOD; i++)
      tick(($urandom_range(3) == 0), int'($urandom_range(31)));
    run(2 * PERIOD);

    // count discontinuity 6 -> 9
    run_to(6);
    tick(1'b0, 0);
    tb_cnt = 9;
    run(2 * PERIOD);

    // reset at count 7 with pending 9 held
    run_to(3);
    tick(1'b1, 9);
    run_to(7);
    apply_reset("midreset");
    run(3 * PERIOD);

`ifdef PWM_WRAP_CNT_EN
    for (int i = 0; i < 256; i++) begin
      tick(($urandom_range(7) == 0), int'($urandom_range(31)));
      run(PERIOD - 1);
    end
`endif

    @(negedge clk);
    duty_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
